// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit:
// FSM states, ALU operation codes, opcode map and datapath mux selects.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_NONE
  } class_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic       ADDR_PC       = 1'b0;
  localparam logic       ADDR_ALUOUT   = 1'b1;
  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;
  localparam logic [1:0] SRC1_PC       = 2'd0;
  localparam logic [1:0] SRC1_OLDPC    = 2'd1;
  localparam logic [1:0] SRC1_RS1      = 2'd2;
  localparam logic [1:0] SRC1_ZERO     = 2'd3;
  localparam logic [1:0] SRC2_RS2      = 2'd0;
  localparam logic [1:0] SRC2_IMM      = 2'd1;
  localparam logic [1:0] SRC2_FOUR     = 2'd2;
  localparam logic [1:0] WB_ALUOUT     = 2'd0;
  localparam logic [1:0] WB_MDR        = 2'd1;
  localparam logic [1:0] WB_PC4        = 2'd2;

  function automatic class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_OP:     return CLS_OP;
      default:    return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational ALU-operation decoder: instruction class plus funct fields
// give the ALU operation, branch flag inversion and an illegal-encoding flag.
module alu_op_decode
  import multicycle_pkg::*;
(
  input  class_e     cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output logic       branch_inv,
  output logic       illegal
);

  always_comb begin
    alu_op     = ALU_ADD;
    branch_inv = 1'b0;
    illegal    = 1'b0;
    case (cls)
      CLS_OP, CLS_OP_IMM: begin
        case (funct3)
          3'b000:  alu_op = (cls == CLS_OP && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        // odd funct3 values are the negated compares (BNE/BGE/BGEU)
        branch_inv = funct3[0];
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      CLS_NONE: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory handshake, retired-instruction counter and halt on illegal opcodes.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_inv,
  output logic                pc_src,
  output logic [1:0]          alu_src1,
  output logic [1:0]          alu_src2,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_src,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             illegal_reg;
  class_e           cls;
  logic [3:0]       dec_alu_op;
  logic [3:0]       alu_sel;
  logic             dec_branch_inv;
  logic             dec_illegal;
  logic             mem_done;
  logic             retire;

  assign cls = classify(opcode);

  alu_op_decode u_alu_op_decode (
    .cls        (cls),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_op     (dec_alu_op),
    .branch_inv (dec_branch_inv),
    .illegal    (dec_illegal)
  );

  // Without the handshake every access is treated as completing at once.
  assign mem_done = !MEM_WAIT || mem_ready;

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_src  = ADDR_PC;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_inv    = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src1      = SRC1_PC;
    alu_src2      = SRC2_RS2;
    alu_sel       = ALU_ADD;
    reg_write     = 1'b0;
    wb_src        = WB_ALUOUT;
    halted        = 1'b0;
    retire        = 1'b0;
    state_next    = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (run) begin
          mem_req  = 1'b1;
          alu_src2 = SRC2_FOUR;
          if (mem_done) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        // branch/JAL target computed here and captured in ALU-out
        alu_src1   = SRC1_OLDPC;
        alu_src2   = SRC2_IMM;
        state_next = dec_illegal ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_WB;
        case (cls)
          CLS_OP: begin
            alu_src1 = SRC1_RS1;
            alu_sel  = dec_alu_op;
          end
          CLS_OP_IMM: begin
            alu_src1 = SRC1_RS1;
            alu_src2 = SRC2_IMM;
            alu_sel  = dec_alu_op;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src1   = SRC1_RS1;
            alu_src2   = SRC2_IMM;
            state_next = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_src1      = SRC1_RS1;
            alu_sel       = dec_alu_op;
            branch_inv    = dec_branch_inv;
            pc_write_cond = 1'b1;
            pc_src        = PC_SRC_ALUOUT;
            state_next    = ST_FETCH;
            retire        = 1'b1;
          end
          CLS_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_ALUOUT;
          end
          CLS_JALR: begin
            alu_src1 = SRC1_RS1;
            alu_src2 = SRC2_IMM;
            pc_write = 1'b1;
          end
          CLS_LUI: begin
            alu_src1 = SRC1_ZERO;
            alu_src2 = SRC2_IMM;
          end
          CLS_AUIPC: begin
            alu_src1 = SRC1_OLDPC;
            alu_src2 = SRC2_IMM;
          end
          default: state_next = ST_HALT;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = ADDR_ALUOUT;
        mem_we       = (cls == CLS_STORE);
        if (mem_done) begin
          if (cls == CLS_STORE) begin
            state_next = ST_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        if (cls == CLS_LOAD) begin
          wb_src = WB_MDR;
        end else if (cls == CLS_JAL || cls == CLS_JALR) begin
          wb_src = WB_PC4;
        end
        state_next = ST_FETCH;
        retire     = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_FETCH;
      retired_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
      if (state_next == ST_HALT && state_reg != ST_HALT) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  assign alu_op  = ALU_OP_W'(alu_sel);
  assign state   = state_reg;
  assign retired = retired_reg;
  assign illegal = illegal_reg;

endmodule
